// File: rtl/routing_tile_cfg.sv
// rtl/routing_tile_cfg.sv - parametrised disjoint-switch-box routing tile with per-track config registers
module routing_tile_cfg #(
    parameter int NUM_SIDES   = 4,   // disjoint pattern is only defined for 4 sides
    parameter int NUM_TRACKS  = 4,
    parameter int TRACK_WIDTH = 1,
    parameter int TILE_ID_W   = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [TILE_ID_W-1:0]                       tile_id,
    input  logic [31:0]                                config_addr,
    input  logic [31:0]                                config_data,
    input  logic                                       config_en,
    input  logic                                       config_rd,
    output logic [31:0]                                read_data,
    output logic                                       read_valid,
    input  logic [NUM_SIDES*NUM_TRACKS*TRACK_WIDTH-1:0] in_wires,
    output logic [NUM_SIDES*NUM_TRACKS*TRACK_WIDTH-1:0] out_wires
);

    localparam int N = NUM_SIDES * NUM_TRACKS;

    // Per-output-track config: [1:0] source select, [2] pipeline enable
    logic [2:0]             cfg_q  [N];
    logic [2:0]             cfg_d  [N];
    logic [TRACK_WIDTH-1:0] pipe_q [N];
    logic [TRACK_WIDTH-1:0] pipe_d [N];
    logic [TRACK_WIDTH-1:0] mux_trk[N];
    logic [31:0]            read_data_q, read_data_d;
    logic                   read_valid_q, read_valid_d;

    logic        hit;
    logic [15:0] idx;
    logic        unused_data;

    assign hit         = (config_addr[16 +: TILE_ID_W] == tile_id);
    assign idx         = config_addr[15:0];
    assign unused_data = ^config_data[31:3];

    // Config register writes; an out-of-range index matches no register and is dropped
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cfg_d[i] = cfg_q[i];
            if (config_en && hit && (idx == 16'(i))) begin
                cfg_d[i] = config_data[2:0];
            end
        end
    end

    // Readback captures the pre-write contents; out-of-range reads return zero
    always_comb begin
        read_valid_d = config_rd && hit;
        read_data_d  = read_data_q;
        if (config_rd && hit) begin
            read_data_d = '0;
            for (int i = 0; i < N; i++) begin
                if (idx == 16'(i)) begin
                    read_data_d = {29'd0, cfg_q[i]};
                end
            end
        end
    end

    // Disjoint switch box: output (s,t) draws from input track t of side (s+sel)%4, sel=0 drives 0
    always_comb begin
        for (int i = 0; i < N; i++) begin
            mux_trk[i] = '0;
        end
        for (int s = 0; s < NUM_SIDES; s++) begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                case (cfg_q[s*NUM_TRACKS+t][1:0])
                    2'd1:    mux_trk[s*NUM_TRACKS+t] = in_wires[(((s+1)%NUM_SIDES)*NUM_TRACKS+t)*TRACK_WIDTH +: TRACK_WIDTH];
                    2'd2:    mux_trk[s*NUM_TRACKS+t] = in_wires[(((s+2)%NUM_SIDES)*NUM_TRACKS+t)*TRACK_WIDTH +: TRACK_WIDTH];
                    2'd3:    mux_trk[s*NUM_TRACKS+t] = in_wires[(((s+3)%NUM_SIDES)*NUM_TRACKS+t)*TRACK_WIDTH +: TRACK_WIDTH];
                    default: mux_trk[s*NUM_TRACKS+t] = '0;
                endcase
            end
        end
    end

    // Pipeline flops load every cycle so re-enabling never exposes stale data
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pipe_d[i] = mux_trk[i];
        end
    end

    // Output select: registered path when reg_en is set, otherwise straight from the mux
    always_comb begin
        out_wires = '0;
        for (int i = 0; i < N; i++) begin
            out_wires[i*TRACK_WIDTH +: TRACK_WIDTH] = cfg_q[i][2] ? pipe_q[i] : mux_trk[i];
        end
    end

    // State registers; reset clears config so every output falls to zero at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                cfg_q[i]  <= '0;
                pipe_q[i] <= '0;
            end
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cfg_q[i]  <= cfg_d[i];
                pipe_q[i] <= pipe_d[i];
            end
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_routing_tile_cfg.sv
// tb/tb_routing_tile_cfg.sv - randomized and directed bench for routing_tile_cfg against a behavioural model
module tb_routing_tile_cfg;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  tile_id = 16'd3;
    logic [31:0]  config_addr = '0;
    logic [31:0]  config_data = '0;
    logic         config_en = 1'b0;
    logic         config_rd = 1'b0;
    logic [31:0]  read_data;
    logic         read_valid;
    logic [15:0]  in_wires = '0;
    logic [15:0]  out_wires;

    logic [31:0]  b_addr = '0;
    logic [31:0]  b_data = '0;
    logic         b_en = 1'b0;
    logic         b_rd = 1'b0;
    logic [31:0]  b_rdata;
    logic         b_rv;
    logic [127:0] b_in = '0;
    logic [127:0] b_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    routing_tile_cfg dut (
        .clk(clk), .reset(rst_n), .tile_id(tile_id),
        .config_addr(config_addr), .config_data(config_data),
        .config_en(config_en), .config_rd(config_rd),
        .read_data(read_data), .read_valid(read_valid),
        .in_wires(in_wires), .out_wires(out_wires)
    );

    routing_tile_cfg #(.NUM_SIDES(4), .NUM_TRACKS(8), .TRACK_WIDTH(4), .TILE_ID_W(16)) dut_b (
        .clk(clk), .reset(rst_n), .tile_id(tile_id),
        .config_addr(b_addr), .config_data(b_data),
        .config_en(b_en), .config_rd(b_rd),
        .read_data(b_rdata), .read_valid(b_rv),
        .in_wires(b_in), .out_wires(b_out)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the default (4x4x1) tile ----------------
    int          cfg_m [16];
    logic [15:0] pipe_m;
    logic        rv_m;
    logic [31:0] rd_m;

    function automatic logic mux_m(input int s, input int t, input logic [15:0] w);
        int sel;
        sel = cfg_m[s*4+t] & 3;
        if (sel == 0) return 1'b0;
        return w[((s + sel) % 4) * 4 + t];
    endfunction

    function automatic logic [15:0] exp_out(input logic [15:0] w);
        logic [15:0] e;
        for (int i = 0; i < 16; i++) begin
            e[i] = ((cfg_m[i] & 4) != 0) ? pipe_m[i] : mux_m(i / 4, i % 4, w);
        end
        return e;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[15:0]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) cfg_m[i] <= 0;
            pipe_m <= '0;
            rv_m   <= 1'b0;
            rd_m   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) pipe_m[i] <= mux_m(i / 4, i % 4, in_wires);
            rv_m <= config_rd && (config_addr[31:16] == tile_id);
            if (config_rd && (config_addr[31:16] == tile_id))
                rd_m <= (idx_of(config_addr) < 16) ? 32'(cfg_m[idx_of(config_addr)]) : 32'd0;
            if (config_en && (config_addr[31:16] == tile_id) && (idx_of(config_addr) < 16))
                cfg_m[idx_of(config_addr)] <= int'(config_data & 32'd7);
        end
    end

    always @(negedge clk) begin
        chk("out_wires", out_wires, exp_out(in_wires));
        chk("read_valid", read_valid, rv_m);
        chk("read_data", read_data, rd_m);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [15:0] tile, input logic [15:0] idx, input logic [31:0] d);
        config_addr = {tile, idx};
        config_data = d;
        config_en   = 1'b1;
        tick();
        config_en   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] tile, input logic [15:0] idx);
        config_addr = {tile, idx};
        config_rd   = 1'b1;
        tick();
        config_rd   = 1'b0;
    endtask

    task automatic bwr(input logic [15:0] idx, input logic [31:0] d);
        b_addr = {16'd3, idx};
        b_data = d;
        b_en   = 1'b1;
        tick();
        b_en   = 1'b0;
    endtask

    task automatic brd(input logic [15:0] idx);
        b_addr = {16'd3, idx};
        b_rd   = 1'b1;
        tick();
        b_rd   = 1'b0;
    endtask

    logic         prev;
    logic [127:0] be;

    initial begin
        // 1: reset holds outputs at zero
        in_wires = '1;
        b_in     = '1;
        #13;
        chk("rst_out", out_wires, 16'h0000);
        chk("rst_rv", read_valid, 1'b0);
        chk("rst_b_out", b_out, 128'h0);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_wires = '0;
        b_in     = '0;
        tick();
        rd(16'd3, 16'd5);
        chk("rd5_valid", read_valid, 1'b1);
        chk("rd5_data", read_data, 32'h0);
        tick();
        chk("rv_one_pulse", read_valid, 1'b0);

        // 2: each select value routes the expected side, combinationally
        wr(16'd3, 16'd0, 32'h1);
        in_wires = 16'h0010; #1;
        chk("sel1_hi", out_wires, 16'h0001);
        in_wires = 16'h0000; #1;
        chk("sel1_lo", out_wires, 16'h0000);
        wr(16'd3, 16'd0, 32'h2);
        in_wires = 16'h0100; #1;
        chk("sel2_hi", out_wires, 16'h0001);
        in_wires = 16'h0010; #1;
        chk("sel2_other", out_wires, 16'h0000);
        wr(16'd3, 16'd0, 32'h3);
        in_wires = 16'h1000; #1;
        chk("sel3_hi", out_wires, 16'h0001);

        // 3: registered path lags by one cycle, then drops back to zero latency
        in_wires = 16'h0000;
        wr(16'd3, 16'd0, 32'h5);
        prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_wires[4] = ~in_wires[4]; #1;
            chk("lag1", out_wires[0], prev);
            prev = in_wires[4];
            tick();
        end
        wr(16'd3, 16'd0, 32'h1);
        for (int k = 0; k < 2; k++) begin
            in_wires[4] = ~in_wires[4]; #1;
            chk("lag0", out_wires[0], in_wires[4]);
            tick();
        end

        // 4: tile miss and out-of-range index
        wr(16'd4, 16'd2, 32'h5);
        rd(16'd3, 16'd2);
        chk("miss_wr_valid", read_valid, 1'b1);
        chk("miss_wr_data", read_data, 32'h0);
        rd(16'd4, 16'd2);
        chk("miss_rd_valid", read_valid, 1'b0);
        rd(16'd3, 16'd0);
        chk("rd0_data", read_data, 32'h1);
        rd(16'd3, 16'd16);
        chk("oor_valid", read_valid, 1'b1);
        chk("oor_data", read_data, 32'h0);

        // 5: same-cycle read/write returns old value; upper bits read as zero
        config_addr = {16'd3, 16'd7};
        config_data = 32'h3;
        config_en   = 1'b1;
        config_rd   = 1'b1;
        tick();
        config_en   = 1'b0;
        config_rd   = 1'b0;
        chk("rw_old_valid", read_valid, 1'b1);
        chk("rw_old_data", read_data, 32'h0);
        rd(16'd3, 16'd7);
        chk("rw_new_data", read_data, 32'h3);
        wr(16'd3, 16'd7, 32'hFFFF_FFFF);
        rd(16'd3, 16'd7);
        chk("mask_data", read_data, 32'h7);

        // 6: reset during a pending read discards it and clears registered outputs at once
        wr(16'd3, 16'd0, 32'h5);
        in_wires = 16'h0010;
        tick();
        tick();
        chk("pre_rst_reg", out_wires[0], 1'b1);
        config_addr = {16'd3, 16'd0};
        config_rd   = 1'b1;
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_out", out_wires, 16'h0000);
        chk("async_rv", read_valid, 1'b0);
        chk("async_rd", read_data, 32'h0);
        config_rd = 1'b0;
        tick();
        tick();
        chk("rst_no_pulse", read_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            in_wires    = 16'($urandom);
            config_en   = ($urandom_range(0, 2) == 0);
            config_rd   = ($urandom_range(0, 2) == 0);
            config_addr = {($urandom_range(0, 3) == 0) ? 16'd4 : 16'd3, 16'($urandom_range(0, 19))};
            config_data = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #4 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end
        config_en = 1'b0;
        config_rd = 1'b0;
        tick();

        // wide variant: 8 tracks of 4 bits, track 6 of side 0
        b_in = '0;
        b_in[(8+6)*4 +: 4] = 4'hA;
        bwr(16'd6, 32'h1); #1;
        be = '0; be[6*4 +: 4] = 4'hA;
        chk("b_sel1", b_out, be);
        b_in = '0;
        b_in[(16+6)*4 +: 4] = 4'hA;
        bwr(16'd6, 32'h2); #1;
        chk("b_sel2", b_out, be);
        b_in = '0;
        b_in[(24+6)*4 +: 4] = 4'hA;
        bwr(16'd6, 32'h3); #1;
        chk("b_sel3", b_out, be);
        b_in = '0; #1;
        chk("b_sel3_lo", b_out, 128'h0);
        bwr(16'd31, 32'h3);
        brd(16'd31);
        chk("b_rd31_valid", b_rv, 1'b1);
        chk("b_rd31_data", b_rdata, 32'h3);
        brd(16'd32);
        chk("b_oor_valid", b_rv, 1'b1);
        chk("b_oor_data", b_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
